// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one 4-bit BCD digit per clock, least significant digit first.
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [4*DIGITS-1:0] a_in,
    input  logic [4*DIGITS-1:0] b_in,
    input  logic                cin,
    output logic [4*DIGITS-1:0] sum_out,
    output logic                cout,
    output logic                done,
    output logic                busy,
    output logic                bad_digit
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_acc;
    logic             r_carry;
    logic             r_bad;
    logic [IDX_W-1:0] r_idx;

    logic [1:0]       w_next_state;
    logic             w_last;
    logic [4:0]       w_raw;
    logic [4:0]       w_adj;
    logic             w_gt9;
    logic [3:0]       w_digit;
    logic             w_bad_next;
    logic [W-1:0]     w_acc_next;

    // Ready only while idle and out of reset
    assign start_ready = (r_state == S_IDLE) && rst_n;

    // Single-digit BCD step on the current low digit of the shifting operands
    always_comb begin
        w_last     = (r_idx == IDX_W'(DIGITS - 1));
        w_raw      = 5'(r_a[3:0]) + 5'(r_b[3:0]) + 5'(r_carry);
        w_adj      = w_raw + 5'd6;
        w_gt9      = (w_raw > 5'd9);
        w_digit    = w_gt9 ? w_adj[3:0] : w_raw[3:0];
        w_bad_next = r_bad | (r_a[3:0] > 4'd9) | (r_b[3:0] > 4'd9);
        w_acc_next = (r_acc >> 4) | (W'(w_digit) << (W - 4));
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start_valid) w_next_state = S_ADD;
            S_ADD:   if (w_last)      w_next_state = S_DONE;
            S_DONE:                   w_next_state = S_IDLE;
            default:                  w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Operand capture, digit accumulation and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_bad     <= 1'b0;
            r_idx     <= '0;
            sum_out   <= '0;
            cout      <= 1'b0;
            bad_digit <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_carry <= cin;
                        r_bad   <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                S_ADD: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_gt9;
                    r_bad   <= w_bad_next;
                    r_idx   <= r_idx + IDX_W'(1);
                    r_acc   <= w_acc_next;
                    if (w_last) begin
                        sum_out   <= w_acc_next;
                        cout      <= w_gt9;
                        bad_digit <= w_bad_next;
                    end
                end
                default: ;
            endcase
            done <= (r_state == S_ADD) && w_last;
            busy <= (w_next_state != S_IDLE);
        end
    end

endmodule
